// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice resolved per stage,
// carry registered between stages, global stall driven by the output handshake.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    // Handshake: a token moves in on in_valid && in_ready and out on out_valid && out_ready.
    // Any unaccepted result freezes the whole pipe, so in_ready is simply !stall.
    logic stall;

    // Register 0 captures the operands (B already conditioned by mode, carry-in = mode);
    // register k holds the token after slice k-1 has been resolved; register STAGES is the output.
    logic [STAGES:0]    v;
    logic [WIDTH-1:0]   ra [0:STAGES-1];
    logic [WIDTH-1:0]   rb [0:STAGES-1];
    logic               rc [0:STAGES-1];
    logic [WIDTH-1:0]   rs [0:STAGES];

    logic [CHUNK:0]     t    [1:STAGES];
    logic [WIDTH-1:0]   rs_n [1:STAGES];
    logic               ovf_n;
    logic               zero_n;

    assign stall     = v[STAGES] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v[STAGES];
    assign sum       = rs[STAGES];

    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            t[k]    = {1'b0, ra[k-1][(k-1)*CHUNK +: CHUNK]}
                    + {1'b0, rb[k-1][(k-1)*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(rc[k-1]);
            rs_n[k] = rs[k-1];
            rs_n[k][(k-1)*CHUNK +: CHUNK] = t[k][CHUNK-1:0];
        end
        ovf_n  = (ra[STAGES-1][WIDTH-1] == rb[STAGES-1][WIDTH-1])
              && (rs_n[STAGES][WIDTH-1] != ra[STAGES-1][WIDTH-1]);
        zero_n = (rs_n[STAGES] == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rc[k] <= 1'b0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                rs[k] <= '0;
            end
        end else if (!stall) begin
            v[0]  <= in_valid;
            ra[0] <= a;
            rb[0] <= b ^ {WIDTH{mode}};
            rc[0] <= mode;
            for (int k = 1; k < STAGES; k++) begin
                v[k]  <= v[k-1];
                ra[k] <= ra[k-1];
                rb[k] <= rb[k-1];
                rc[k] <= t[k][CHUNK];
                rs[k] <= rs_n[k];
            end
            // Final slice: sum and flags are registered together as the output stage.
            v[STAGES]  <= v[STAGES-1];
            rs[STAGES] <= rs_n[STAGES];
            cout       <= t[STAGES][CHUNK];
            ovf        <= ovf_n;
            zero       <= zero_n;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed checks on a 16/4 instance plus scoreboarded random
// traffic on 16/4, 8/8 and 32/8 instances sharing one clock and reset.
module tb_addsub_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_pop16 = 0;

    logic        iv16, ir16, m16, ov16, or16, c16, o16, z16;
    logic [15:0] a16, b16, s16;
    logic        iv8, ir8, m8, ov8, or8, c8, o8, z8;
    logic [7:0]  a8, b8, s8;
    logic        iv32, ir32, m32, ov32, or32, c32, o32, z32;
    logic [31:0] a32, b32, s32;

    logic [34:0] exp_q16[$];
    logic [34:0] exp_q8[$];
    logic [34:0] exp_q32[$];

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .mode(m16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(c16), .ovf(o16), .zero(z16));
    addsub_pipe #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .mode(m8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(c8), .ovf(o8), .zero(z8));
    addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .mode(m32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(c32), .ovf(o32), .zero(z32));

    // Reference: plain integer arithmetic, returns {cout, ovf, zero, sum}.
    function automatic logic [34:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic m);
        longint ux, uy, sx, sy, ur, sr, half;
        logic [31:0] s;
        logic c, o, z;
        ux   = longint'(x);
        uy   = longint'(y);
        half = longint'(1) << (w - 1);
        sx   = x[w-1] ? ux - 2 * half : ux;
        sy   = y[w-1] ? uy - 2 * half : uy;
        if (m) begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur >= 2 * half);
        end
        s = 32'(ur & (2 * half - 1));
        o = (sr >= half) || (sr < -half);
        z = (s == 32'd0);
        return {c, o, z, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: at negedge score handshakes on all instances, then return just after posedge.
    task automatic cycle();
        @(negedge clk);
        chk("in_ready16", {63'b0, ir16}, {63'b0, !(ov16 && !or16)});
        if (ov16 && or16) begin
            chk("sb16_pending", {63'b0, exp_q16.size() != 0}, 64'd1);
            if (exp_q16.size() != 0) begin
                chk("result16", {29'b0, c16, o16, z16, 16'b0, s16}, {29'b0, exp_q16.pop_front()});
                n_pop16++;
            end
        end
        if (ov8 && or8) begin
            chk("sb8_pending", {63'b0, exp_q8.size() != 0}, 64'd1);
            if (exp_q8.size() != 0)
                chk("result8", {29'b0, c8, o8, z8, 24'b0, s8}, {29'b0, exp_q8.pop_front()});
        end
        if (ov32 && or32) begin
            chk("sb32_pending", {63'b0, exp_q32.size() != 0}, 64'd1);
            if (exp_q32.size() != 0)
                chk("result32", {29'b0, c32, o32, z32, s32}, {29'b0, exp_q32.pop_front()});
        end
        if (iv16 && ir16) exp_q16.push_back(model(16, {16'b0, a16}, {16'b0, b16}, m16));
        if (iv8 && ir8)   exp_q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, m8));
        if (iv32 && ir32) exp_q32.push_back(model(32, a32, b32, m32));
        @(posedge clk);
        #1;
    endtask

    // Single token on the 16/4 instance; checks latency and the spec-given result.
    task automatic run_vec(input logic [15:0] av, input logic [15:0] bv, input logic mv,
                           input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        int n;
        a16 = av; b16 = bv; m16 = mv; iv16 = 1'b1; or16 = 1'b1;
        cycle();
        iv16 = 1'b0;
        a16  = 16'($urandom);
        b16  = 16'($urandom);
        n    = 0;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            cycle();
            if (ov16) n = i;
        end
        chk("latency16", 64'(n), 64'd4);
        chk("vec_sum", {48'b0, s16}, {48'b0, es});
        chk("vec_flags", {61'b0, c16, o16, z16}, {61'b0, ec, eo, ez});
    endtask

    initial begin
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic [19:0] held;
        logic        prev_stall, acc;
        int          idx, pop0, seen;

        rst_n = 1'b0;
        iv16 = 0; a16 = 0; b16 = 0; m16 = 0; or16 = 1;
        iv8  = 0; a8  = 0; b8  = 0; m8  = 0; or8  = 1;
        iv32 = 0; a32 = 0; b32 = 0; m32 = 0; or32 = 1;
        #1;
        cycle();
        cycle();
        chk("rst_state16", {59'b0, ov16, c16, o16, z16, ir16}, 64'd1);
        chk("rst_sum16", {48'b0, s16}, 64'd0);
        chk("rst_state8", {59'b0, ov8, c8, o8, z8, ir8}, 64'd1);
        chk("rst_state32", {27'b0, ov32, c32, o32, z32, s32}, 64'd0);
        rst_n = 1'b1;
        cycle();

        run_vec(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_vec(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_vec(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_vec(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_vec(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_vec(16'h0003, 16'h0003, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        cycle();

        // Eight back-to-back tokens, alternating mode, consumer stalls for three cycles.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        idx = 0; pop0 = n_pop16; prev_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && (idx < 8 || exp_q16.size() != 0); cyc++) begin
            iv16 = (idx < 8);
            if (idx < 8) begin
                a16 = sa[idx];
                b16 = sb[idx];
                m16 = idx[0];
            end
            or16 = !(cyc >= 6 && cyc <= 8);
            #1;
            if (ov16 && !or16) begin
                chk("in_ready_stall", {63'b0, ir16}, 64'd0);
                if (prev_stall) chk("stall_hold", {44'b0, ov16, c16, o16, z16, s16}, {44'b0, held});
                held = {ov16, c16, o16, z16, s16};
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            acc = iv16 && ir16;
            cycle();
            if (acc) idx++;
        end
        iv16 = 1'b0; or16 = 1'b1;
        chk("burst_count", 64'(n_pop16 - pop0), 64'd8);
        chk("burst_drained", 64'(exp_q16.size()), 64'd0);

        // Reset with three tokens in flight: none may ever come out.
        for (int i = 0; i < 3; i++) begin
            iv16 = 1'b1;
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            m16  = 1'($urandom);
            cycle();
        end
        iv16  = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        exp_q16.delete();
        chk("midrst_state", {59'b0, ov16, c16, o16, z16, ir16}, 64'd1);
        chk("midrst_sum", {48'b0, s16}, 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (ov16) seen++;
        end
        chk("no_ghost", 64'(seen), 64'd0);
        run_vec(16'hA5A5, 16'h1111, 1'b1, 16'h9494, 1'b1, 1'b0, 1'b0);
        cycle();

        // Random traffic on all three instances.
        for (int i = 0; i < 400; i++) begin
            iv16 = 1'($urandom_range(0, 1)); or16 = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom_range(0, 1));
            iv8 = 1'($urandom_range(0, 1)); or8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom_range(0, 1));
            iv32 = 1'($urandom_range(0, 1)); or32 = ($urandom_range(0, 3) != 0);
            a32 = $urandom; b32 = $urandom; m32 = 1'($urandom_range(0, 1));
            cycle();
        end
        iv16 = 0; iv8 = 0; iv32 = 0; or16 = 1; or8 = 1; or32 = 1;
        for (int i = 0; i < 20; i++) cycle();
        chk("drain16", 64'(exp_q16.size()), 64'd0);
        chk("drain8", 64'(exp_q8.size()), 64'd0);
        chk("drain32", 64'(exp_q32.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with per-operation mode select, status flags and a valid/ready handshake on both sides. Operands of WIDTH bits are split into CHUNK-bit slices, one slice resolved per pipeline stage, with the carry registered between stages. It is the arithmetic datapath element for streaming blocks that need one add or subtract result per clock at widths beyond a single-cycle ripple chain.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK, at least 2
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (derived, not overridable)
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
- ovf  output  1  signed overflow
- zero  output  1  sum == 0

## Operation
- Subtract computed as A + (B XOR {WIDTH{mode}}) + mode; carry-in of slice 0 = mode.
- Stage k (0..STAGES-1) adds slice k of A and inverted/plain B with the carry registered from stage k-1; resolved slices and not-yet-used operand slices travel with the token.
- Each stage register carries a valid bit; mode travels with the token.
- ovf = (a_msb == b'_msb) && (sum_msb != a_msb), b' = B after mode inversion.
- zero, ovf, cout computed from the final stage and registered with sum.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready. When stall, every stage register, including valid bits, holds.
- in_ready = !stall (combinational from out_valid register and out_ready).
- No token is dropped or duplicated; results leave in acceptance order.
- Inputs sampled only on transfer; a, b, mode ignored otherwise.

## Timing
- Reset (rst_n low at rising edge): all valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, zero 0; in_ready = 1 in the cycle after reset since out_valid = 0.
- Reset mid-operation: all in-flight tokens discarded; no result emitted for them.
- Latency: operand accepted at edge N appears with out_valid = 1 after edge N+STAGES (registered output), assuming no stall.
- Throughput: one result per cycle while out_ready stays high.
- Output held stable (sum, flags, out_valid) for every cycle out_valid && !out_ready.
- Simultaneous output transfer and input transfer in the same cycle permitted; pipeline advances one stage.
- Bubbles (in_valid low) propagate as invalid slots; they are not collapsed.
- STAGES = 1 (CHUNK = WIDTH): single registered stage, latency 1.

## Test plan
- WIDTH=16, CHUNK=4: accept a=0x1234, b=0x0FFF, mode=0 at edge N -> out_valid at edge N+4, sum=0x2233, cout=0, ovf=0, zero=0.
- Subtract a=0x0005, b=0x0007, mode=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0, zero=0; a=0x8000, b=0x0001, mode=1 -> sum=0x7FFF, cout=1, ovf=1.
- Add a=0xFFFF, b=0x0001, mode=0 -> sum=0x0000, cout=1, zero=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
- Back-to-back 8 tokens alternating mode, out_ready low for 3 cycles mid-stream -> in_ready low during stall, outputs held, all 8 results correct and in order, no loss or duplication.
- Assert rst_n low for one cycle with 3 tokens in flight -> out_valid 0 and all outputs 0 next cycle, none of the 3 results ever emitted; new token after reset returns after 4 cycles.
- Random constrained stimulus (random in_valid/out_ready, both modes) for WIDTH=16/CHUNK=4, WIDTH=8/CHUNK=8, WIDTH=32/CHUNK=8 -> every result matches scoreboard of (A ± B) mod 2^WIDTH with cout/ovf/zero.
